// File: rtl/elevator_pkg.sv
// elevator_pkg: state encoding and motor/speed codes shared by the elevator controllers
package elevator_pkg;
  typedef enum logic [2:0] {INIT, IDLE, MOVE_UP, MOVE_DN, CHIME, OPEN, DWELL, CLOSE} state_t;
  localparam logic [1:0] MD_HOIST_DN = 2'b00, MD_HOIST_UP = 2'b01, MD_DOOR_CLOSE = 2'b10, MD_DOOR_OPEN = 2'b11;
  localparam logic [1:0] PW_STOP = 2'b00, PW_SLOW = 2'b01, PW_MED = 2'b10, PW_FAST = 2'b11;
endpackage

// File: rtl/elevator_req_reg.sv
// elevator_req_reg: pending call register with at/above/below and next-floor lookahead flags
module elevator_req_reg
  import elevator_pkg::*;
#(
  parameter int FLOORS = 4,
  localparam int FLOOR_W = $clog2(FLOORS)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [FLOORS-1:0]  calls,
  input  logic [FLOORS-1:0]  clr,
  input  logic [FLOOR_W-1:0] floor,
  output logic               at,
  output logic               above,
  output logic               below,
  output logic               nxt_up,
  output logic               nxt_dn
);
  logic [FLOORS-1:0] pending;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) pending <= '0;
    else pending <= (pending | calls) & ~clr;
  always_comb begin
    at = 1'b0;
    above = 1'b0;
    below = 1'b0;
    nxt_up = 1'b0;
    nxt_dn = 1'b0;
    for (int k = 0; k < FLOORS; k++) begin
      at = at | (pending[k] && k == int'(floor));
      above = above | (pending[k] && k > int'(floor));
      below = below | (pending[k] && k < int'(floor));
      nxt_up = nxt_up | (pending[k] && k == int'(floor) + 1);
      nxt_dn = nxt_dn | (pending[k] && k + 1 == int'(floor));
    end
  end
endmodule

// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: N-floor SCAN elevator controller with chime, door dwell timer and Moore motor outputs
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int FLOORS = 4,
  parameter int DOOR_CYCLES = 8,
  parameter int CHIME_CYCLES = 2,
  localparam int FLOOR_W = $clog2(FLOORS)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [FLOORS-1:0]  I,
  input  logic [FLOORS-1:0]  E,
  input  logic [FLOORS-1:0]  Sen,
  output logic               M,
  output logic               D,
  output logic               P,
  output logic               W,
  output logic               S,
  output logic [FLOOR_W-1:0] Floor,
  output logic               Busy
);
  localparam int TMAX = DOOR_CYCLES > CHIME_CYCLES ? DOOR_CYCLES : CHIME_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  state_t state, nxt;
  logic dir, dir_nxt;
  logic [FLOOR_W-1:0] floor_nxt, sen_idx;
  logic [TW-1:0] timer;
  logic [FLOORS-1:0] clr;
  logic sen_ok, up_hit, dn_hit, at_call, restart;
  logic at, above, below, nxt_up, nxt_dn;
  assign clr = (state == OPEN || state == DWELL) ? FLOORS'(1) << Floor : '0;
  elevator_req_reg #(.FLOORS(FLOORS)) u_req (
    .Clk(Clk), .Reset_n(Reset_n), .calls(I | E), .clr(clr), .floor(Floor),
    .at(at), .above(above), .below(below), .nxt_up(nxt_up), .nxt_dn(nxt_dn)
  );
  // multi-hot sensor words are treated as "between floors"
  always_comb begin
    sen_idx = '0;
    at_call = 1'b0;
    for (int k = 0; k < FLOORS; k++) begin
      if (Sen[k]) sen_idx = FLOOR_W'(k);
      at_call = at_call | ((I[k] | E[k]) && k == int'(Floor));
    end
  end
  assign sen_ok = $onehot(Sen);
  assign up_hit = sen_ok && int'(sen_idx) == int'(Floor) + 1;
  assign dn_hit = sen_ok && int'(sen_idx) + 1 == int'(Floor);
  assign restart = state == DWELL && at_call;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state <= INIT;
      dir <= 1'b1;
      Floor <= '0;
      timer <= '0;
    end else begin
      state <= nxt;
      dir <= dir_nxt;
      Floor <= floor_nxt;
      timer <= (nxt != state || restart) ? '0 : timer == TW'(TMAX) ? timer : timer + TW'(1);
    end
  always_comb begin
    nxt = state;
    dir_nxt = dir;
    floor_nxt = Floor;
    case (state)
      INIT: if (sen_ok) begin
        floor_nxt = sen_idx;
        nxt = IDLE;
      end
      IDLE: if (at) nxt = CHIME;
      else if (dir ? above : below) nxt = dir ? MOVE_UP : MOVE_DN;
      else if (dir ? below : above) begin
        nxt = dir ? MOVE_DN : MOVE_UP;
        dir_nxt = !dir;
      end
      MOVE_UP: if (up_hit) begin
        floor_nxt = Floor + FLOOR_W'(1);
        nxt = nxt_up ? CHIME : MOVE_UP;
      end
      MOVE_DN: if (dn_hit) begin
        floor_nxt = Floor - FLOOR_W'(1);
        nxt = nxt_dn ? CHIME : MOVE_DN;
      end
      CHIME: if (timer == TW'(CHIME_CYCLES - 1)) nxt = OPEN;
      OPEN: nxt = DWELL;
      DWELL: if (timer == TW'(DOOR_CYCLES - 1) && !restart) nxt = CLOSE;
      CLOSE: nxt = IDLE;
      default: nxt = INIT;
    endcase
  end
  // slow to medium one floor before a stop or the end of travel
  always_comb begin
    {M, D} = state == OPEN ? MD_DOOR_OPEN : state == CLOSE ? MD_DOOR_CLOSE :
             state == MOVE_UP ? MD_HOIST_UP : MD_HOIST_DN;
    {P, W} = (state == OPEN || state == CLOSE) ? PW_SLOW :
             state == MOVE_UP ? ((nxt_up || int'(Floor) == FLOORS - 2) ? PW_MED : PW_FAST) :
             state == MOVE_DN ? ((nxt_dn || int'(Floor) == 1) ? PW_MED : PW_FAST) : PW_STOP;
    S = state == CHIME;
    Busy = state != IDLE;
  end
endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// tb_elevator_scan_ctrl: run-length scoreboard of the Moore output trace across SCAN scenarios
module tb_elevator_scan_ctrl;
  typedef struct packed {logic [5:0] ctl; logic [3:0] flr; logic [15:0] len;} run_t;
  localparam logic [5:0] C_INIT = 6'b100000, C_IDLE = 6'b000000, C_UPF = 6'b101110, C_UPM = 6'b101100;
  localparam logic [5:0] C_DNF = 6'b100110, C_DNM = 6'b100100, C_CHIME = 6'b100001, C_OPEN = 6'b111010;
  localparam logic [5:0] C_DWELL = 6'b100000, C_CLOSE = 6'b110010;
  logic Clk = 1'b0, Reset_n = 1'b1;
  logic [3:0] I = '0, E = '0, Sen = '0;
  logic M, D, P, W, S, Busy;
  logic [1:0] Floor;
  int tests = 0, fails = 0;
  run_t exp_q[$], obs_q[$];
  logic have_run = 1'b0;
  logic [5:0] run_ctl;
  logic [3:0] run_flr;
  logic [15:0] run_len;
  elevator_scan_ctrl #(.FLOORS(4), .DOOR_CYCLES(8), .CHIME_CYCLES(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .I(I), .E(E), .Sen(Sen),
    .M(M), .D(D), .P(P), .W(W), .S(S), .Floor(Floor), .Busy(Busy)
  );
  always #5 Clk = ~Clk;
  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
      if (have_run && run_ctl == {Busy, M, D, P, W, S} && run_flr == 4'(Floor)) run_len++;
      else begin
        if (have_run) obs_q.push_back({run_ctl, run_flr, run_len});
        run_ctl = {Busy, M, D, P, W, S};
        run_flr = 4'(Floor);
        run_len = 1;
        have_run = 1'b1;
      end
    end
  endtask
  task automatic flush();
    if (have_run) obs_q.push_back({run_ctl, run_flr, run_len});
    have_run = 1'b0;
  endtask
  task automatic exp_run(input logic [5:0] c, input int f, input int n);
    exp_q.push_back({c, 4'(f), 16'(n)});
  endtask
  task automatic test_reset();
    run_t e, o;
    exp_run(C_INIT, 0, 4); exp_run(C_IDLE, 0, 4);
    #2 Reset_n = 1'b0;
    #1;
    tests++;
    if ({M, D, P, W, S, Busy, Floor} !== 8'b00000100) begin
      fails++;
      $display("FAIL reset_async got MDPWS=%b Busy=%b Floor=%0d exp 00000/1/0", {M, D, P, W, S}, Busy, Floor);
    end
    step(2); Reset_n = 1'b1; step(2); Sen = 4'b0001; step(4);
    flush();
    tests++;
    if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL reset runs got %0d exp %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL reset run ctl/fl/len got %b/%0d/%0d exp %b/%0d/%0d", o.ctl, o.flr, o.len, e.ctl, e.flr, e.len); end
    end
    exp_q.delete(); obs_q.delete();
  endtask
  task automatic test_travel_up();
    run_t e, o;
    exp_run(C_IDLE, 0, 1); exp_run(C_UPF, 0, 3); exp_run(C_UPF, 1, 3); exp_run(C_UPM, 2, 3);
    exp_run(C_CHIME, 3, 2); exp_run(C_OPEN, 3, 1); exp_run(C_DWELL, 3, 8); exp_run(C_CLOSE, 3, 1); exp_run(C_IDLE, 3, 5);
    I = 4'b1000; step(1); I = '0; step(1);
    Sen = '0; step(2); Sen = 4'b0010; step(1);
    Sen = '0; step(2); Sen = 4'b0100; step(1);
    Sen = '0; step(2); Sen = 4'b1000; step(1);
    step(16);
    flush();
    tests++;
    if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL travel_up runs got %0d exp %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL travel_up run ctl/fl/len got %b/%0d/%0d exp %b/%0d/%0d", o.ctl, o.flr, o.len, e.ctl, e.flr, e.len); end
    end
    exp_q.delete(); obs_q.delete();
  endtask
  task automatic test_scan();
    run_t e, o;
    exp_run(C_INIT, 0, 1); exp_run(C_IDLE, 1, 2); exp_run(C_UPF, 1, 3); exp_run(C_UPM, 2, 3);
    exp_run(C_CHIME, 3, 2); exp_run(C_OPEN, 3, 1); exp_run(C_DWELL, 3, 8); exp_run(C_CLOSE, 3, 1); exp_run(C_IDLE, 3, 1);
    exp_run(C_DNF, 3, 3); exp_run(C_DNF, 2, 3); exp_run(C_DNM, 1, 3);
    exp_run(C_CHIME, 0, 2); exp_run(C_OPEN, 0, 1); exp_run(C_DWELL, 0, 8); exp_run(C_CLOSE, 0, 1); exp_run(C_IDLE, 0, 3);
    Reset_n = 1'b0; Sen = 4'b0010; step(1); Reset_n = 1'b1; step(1);
    I = 4'b1001; step(1); I = '0; step(1);
    Sen = '0; step(2); Sen = 4'b0100; step(1);
    Sen = '0; step(2); Sen = 4'b1000; step(1);
    step(13);
    Sen = '0; step(2); Sen = 4'b0100; step(1);
    Sen = '0; step(2); Sen = 4'b0010; step(1);
    Sen = '0; step(2); Sen = 4'b0001; step(1);
    step(14);
    flush();
    tests++;
    if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL scan runs got %0d exp %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL scan run ctl/fl/len got %b/%0d/%0d exp %b/%0d/%0d", o.ctl, o.flr, o.len, e.ctl, e.flr, e.len); end
    end
    exp_q.delete(); obs_q.delete();
  endtask
  task automatic test_dwell_restart();
    run_t e, o;
    exp_run(C_INIT, 0, 1); exp_run(C_IDLE, 2, 2); exp_run(C_CHIME, 2, 2); exp_run(C_OPEN, 2, 1);
    exp_run(C_DWELL, 2, 14); exp_run(C_CLOSE, 2, 1); exp_run(C_IDLE, 2, 3);
    Reset_n = 1'b0; Sen = 4'b0100; step(1); Reset_n = 1'b1; step(1);
    I = 4'b0100; step(1); I = '0; step(3);
    step(6); E = 4'b0100; step(1); E = '0; step(8);
    step(3);
    flush();
    tests++;
    if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL dwell_restart runs got %0d exp %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL dwell_restart run ctl/fl/len got %b/%0d/%0d exp %b/%0d/%0d", o.ctl, o.flr, o.len, e.ctl, e.flr, e.len); end
    end
    exp_q.delete(); obs_q.delete();
  endtask
  task automatic test_same_cycle();
    run_t e, o;
    exp_run(C_INIT, 0, 1); exp_run(C_IDLE, 1, 2); exp_run(C_CHIME, 1, 2); exp_run(C_OPEN, 1, 1);
    exp_run(C_DWELL, 1, 8); exp_run(C_CLOSE, 1, 1); exp_run(C_IDLE, 1, 1); exp_run(C_UPF, 1, 1);
    Reset_n = 1'b0; Sen = 4'b0010; step(1); Reset_n = 1'b1; step(1);
    I = 4'b0010; E = 4'b1000; step(1); I = '0; E = '0;
    step(14);
    flush();
    tests++;
    if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL same_cycle runs got %0d exp %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL same_cycle run ctl/fl/len got %b/%0d/%0d exp %b/%0d/%0d", o.ctl, o.flr, o.len, e.ctl, e.flr, e.len); end
    end
    exp_q.delete(); obs_q.delete();
  endtask
  task automatic test_invalid_sensor();
    run_t e, o;
    exp_run(C_UPF, 1, 4); exp_run(C_UPM, 2, 2); exp_run(C_CHIME, 3, 2); exp_run(C_OPEN, 3, 1);
    exp_run(C_DWELL, 3, 8); exp_run(C_CLOSE, 3, 1); exp_run(C_IDLE, 3, 1);
    Sen = '0; step(1); Sen = 4'b0110; step(2); Sen = '0; step(1);
    Sen = 4'b0100; step(1); Sen = '0; step(1); Sen = 4'b1000; step(1);
    step(12);
    flush();
    tests++;
    if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL invalid_sensor runs got %0d exp %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL invalid_sensor run ctl/fl/len got %b/%0d/%0d exp %b/%0d/%0d", o.ctl, o.flr, o.len, e.ctl, e.flr, e.len); end
    end
    exp_q.delete(); obs_q.delete();
  endtask
  task automatic test_reset_mid_motion();
    run_t e, o;
    exp_run(C_IDLE, 3, 1); exp_run(C_DNF, 3, 2); exp_run(C_INIT, 0, 1); exp_run(C_IDLE, 2, 3);
    I = 4'b0001; step(1); I = '0; step(1); Sen = '0; step(1);
    Reset_n = 1'b0;
    #1;
    tests++;
    if ({M, D, P, W, S} !== 5'b00000) begin fails++; $display("FAIL mid_reset_motor got MDPWS=%b exp 00000", {M, D, P, W, S}); end
    tests++;
    if ({Busy, Floor} !== 3'b100) begin fails++; $display("FAIL mid_reset_state got Busy=%b Floor=%0d exp 1/0", Busy, Floor); end
    Sen = 4'b0100; step(1); Reset_n = 1'b1; step(3);
    flush();
    tests++;
    if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL mid_reset runs got %0d exp %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL mid_reset run ctl/fl/len got %b/%0d/%0d exp %b/%0d/%0d", o.ctl, o.flr, o.len, e.ctl, e.flr, e.len); end
    end
    exp_q.delete(); obs_q.delete();
  endtask
  initial begin
    test_reset();
    test_travel_up();
    test_scan();
    test_dwell_restart();
    test_same_cycle();
    test_invalid_sensor();
    test_reset_mid_motion();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
